instr_fetch_ctrl: RTL and testbench

//   Instruction-fetch controller: consumer of the branch unit's redirect (take_branch/branch_pc).

---
 rtl/instr_fetch_ctrl_if.sv | 28 ++
 rtl/instr_fetch_ctrl.sv | 146 ++++++++++++++
 tb/tb_instr_fetch_ctrl.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/instr_fetch_ctrl_if.sv
// Instruction-memory request/response port plus the decode-side valid/ready port.
// master: the fetch controller's view; slave: the memory/decode environment's view.
interface instr_fetch_ctrl_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic [31:0] if_pc_plus4;
  logic        if_ready;

  modport master (
    output imem_req, imem_addr,
    input  imem_gnt, imem_rvalid, imem_rdata,
    output if_valid, if_instr, if_pc, if_pc_plus4,
    input  if_ready
  );

  modport slave (
    input  imem_req, imem_addr,
    output imem_gnt, imem_rvalid, imem_rdata,
    input  if_valid, if_instr, if_pc, if_pc_plus4,
    output if_ready
  );
endinterface

// File: rtl/instr_fetch_ctrl.sv
// Instruction-fetch controller: owns the fetch PC, issues one imem request at a time,
// buffers responses in a 2-entry FIFO toward decode and squashes stale fetches on redirect.
module instr_fetch_ctrl #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      take_branch,
  input  logic [31:0]               branch_pc,
  output logic                      fetch_fault,
  instr_fetch_ctrl_if.master        io
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

  localparam logic [2:0] DEPTH = 3'(FIFO_DEPTH);

  state_t      state_q, state_d;
  logic [31:0] fetch_pc_q, fetch_pc_d;
  logic [31:0] req_pc_q, req_pc_d;
  logic        pending_q, pending_d;
  logic        drop_q, drop_d;
  logic        fault_q, fault_d;
  logic [1:0]  occ_q, occ_d;
  logic [31:0] pc_q [2];
  logic [31:0] pc_d [2];
  logic [31:0] instr_q [2];
  logic [31:0] instr_d [2];

  logic        granted;
  logic        resp;
  logic        push;
  logic        pop;
  logic [1:0]  fill;

  always_comb begin
    granted    = (state_q == REQ) && io.imem_gnt;
    resp       = io.imem_rvalid && pending_q;
    push       = resp && !drop_q && !take_branch;
    pop        = (occ_q != 2'd0) && io.if_ready && !take_branch;
    fill       = occ_q - {1'b0, pop};

    pending_d  = pending_q;
    drop_d     = drop_q;
    req_pc_d   = req_pc_q;
    fetch_pc_d = fetch_pc_q;
    fault_d    = take_branch && (branch_pc[1:0] != 2'b00);

    if (resp) begin
      pending_d = 1'b0;
      drop_d    = 1'b0;
    end
    if (granted) begin
      pending_d  = 1'b1;
      req_pc_d   = fetch_pc_q;
      fetch_pc_d = fetch_pc_q + 32'd4;
    end
    // A fetch already accepted by memory must still have its answer swallowed.
    if (take_branch) begin
      fetch_pc_d = {branch_pc[31:2], 2'b00};
      if (granted || ((state_q == WAIT) && !io.imem_rvalid)) begin
        drop_d    = 1'b1;
        pending_d = 1'b1;
      end
    end

    pc_d    = pc_q;
    instr_d = instr_q;
    occ_d   = occ_q;
    if (take_branch) begin
      occ_d = 2'd0;
    end else begin
      if (pop) begin
        pc_d[0]    = pc_q[1];
        instr_d[0] = instr_q[1];
      end
      if (push) begin
        pc_d[fill[0]]    = req_pc_q;
        instr_d[fill[0]] = io.imem_rdata;
      end
      occ_d = occ_q + {1'b0, push} - {1'b0, pop};
    end

    // Only request when the answer is guaranteed a FIFO slot on arrival.
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (!drop_d && (({1'b0, occ_d} + {2'b00, pending_d}) < DEPTH)) begin
          state_d = REQ;
        end
      end
      REQ: begin
        if (io.imem_gnt) begin
          state_d = WAIT;
        end else if (take_branch) begin
          state_d = IDLE;
        end
      end
      WAIT: begin
        if (io.imem_rvalid) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      fetch_pc_q <= RESET_PC;
      req_pc_q   <= 32'h0;
      pending_q  <= 1'b0;
      drop_q     <= 1'b0;
      fault_q    <= 1'b0;
      occ_q      <= 2'd0;
      pc_q[0]    <= 32'h0;
      pc_q[1]    <= 32'h0;
      instr_q[0] <= 32'h0;
      instr_q[1] <= 32'h0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      req_pc_q   <= req_pc_d;
      pending_q  <= pending_d;
      drop_q     <= drop_d;
      fault_q    <= fault_d;
      occ_q      <= occ_d;
      pc_q       <= pc_d;
      instr_q    <= instr_d;
    end
  end

  assign io.imem_req    = (state_q == REQ);
  assign io.imem_addr   = fetch_pc_q;
  assign io.if_valid    = (occ_q != 2'd0);
  assign io.if_pc       = pc_q[0];
  assign io.if_instr    = instr_q[0];
  assign io.if_pc_plus4 = pc_q[0] + 32'd4;
  assign fetch_fault    = fault_q;

  a_rvalid_needs_pending: assert property (@(posedge clk) disable iff (!rst_n)
    io.imem_rvalid |-> pending_q);

endmodule

// File: tb/tb_instr_fetch_ctrl.sv
// Directed bench for instr_fetch_ctrl: reset, streaming, backpressure, redirect/squash, fault, PC wrap.
module tb_instr_fetch_ctrl;
  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        take_branch = 1'b0;
  logic [31:0] branch_pc = 32'h0;
  logic        fetch_fault;
  logic        fetch_fault2;

  instr_fetch_ctrl_if bus ();
  instr_fetch_ctrl_if bus2 ();

  instr_fetch_ctrl #(.RESET_PC(32'h0000_0000), .FIFO_DEPTH(2)) dut (
    .clk(clk), .rst_n(rst_n), .take_branch(take_branch), .branch_pc(branch_pc),
    .fetch_fault(fetch_fault), .io(bus.master)
  );

  instr_fetch_ctrl #(.RESET_PC(32'hFFFF_FFFC), .FIFO_DEPTH(2)) dut_wrap (
    .clk(clk), .rst_n(rst_n), .take_branch(1'b0), .branch_pc(32'h0),
    .fetch_fault(fetch_fault2), .io(bus2.master)
  );

  always #5 clk = ~clk;

  int          errors = 0;
  int          checks = 0;
  int          resp_delay = 1;
  int          mem_cnt = 0;
  bit          mem_pend = 1'b0;
  bit          stale_next = 1'b0;
  bit          stale_seen = 1'b0;
  logic [31:0] mem_addr = 32'h0;

  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return {16'hC0DE, a[15:0]};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
    end else begin
      $display("ok   %s: 0x%08h", tag, got);
    end
  endtask

  // One clock cycle, negedge to negedge, with the memory responders modelled inline.
  task automatic step();
    logic        g;
    logic        g2;
    logic [31:0] a;
    logic [31:0] a2;
    g  = bus.imem_req && bus.imem_gnt;
    a  = bus.imem_addr;
    g2 = bus2.imem_req && bus2.imem_gnt;
    a2 = bus2.imem_addr;
    @(posedge clk);
    @(negedge clk);
    bus.imem_rvalid = 1'b0;
    if (g) begin
      mem_pend = 1'b1;
      mem_cnt  = resp_delay;
      mem_addr = a;
    end
    if (mem_pend) begin
      if (mem_cnt <= 1) begin
        bus.imem_rvalid = 1'b1;
        bus.imem_rdata  = stale_next ? 32'hDEAD_BEEF : instr_of(mem_addr);
        stale_next      = 1'b0;
        mem_pend        = 1'b0;
      end else begin
        mem_cnt--;
      end
    end
    bus2.imem_rvalid = g2;
    bus2.imem_rdata  = instr_of(a2);
    if (bus.if_valid && (bus.if_instr == 32'hDEAD_BEEF)) stale_seen = 1'b1;
  endtask

  task automatic do_reset();
    rst_n            = 1'b0;
    take_branch      = 1'b0;
    branch_pc        = 32'h0;
    bus.imem_rvalid  = 1'b0;
    bus2.imem_rvalid = 1'b0;
    mem_pend         = 1'b0;
    stale_next       = 1'b0;
    resp_delay       = 1;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic wait_req(input string tag, input logic [31:0] exp_addr);
    int n;
    n = 0;
    while (!bus.imem_req && n < 20) begin
      step();
      n++;
    end
    check({tag, "_req"}, 32'(bus.imem_req), 32'd1);
    check({tag, "_addr"}, bus.imem_addr, exp_addr);
  endtask

  task automatic wait_valid(input string tag, input logic [31:0] exp_pc);
    int n;
    n = 0;
    while (!bus.if_valid && n < 20) begin
      step();
      n++;
    end
    check({tag, "_valid"}, 32'(bus.if_valid), 32'd1);
    check({tag, "_pc"}, bus.if_pc, exp_pc);
    check({tag, "_instr"}, bus.if_instr, instr_of(exp_pc));
  endtask

  initial begin
    bus.imem_gnt = 1'b1;  bus.imem_rvalid = 1'b0;  bus.imem_rdata = 32'h0;  bus.if_ready = 1'b1;
    bus2.imem_gnt = 1'b1; bus2.imem_rvalid = 1'b0; bus2.imem_rdata = 32'h0; bus2.if_ready = 1'b1;

    // Reset state
    rst_n = 1'b0;
    @(negedge clk);
    check("rst_req", 32'(bus.imem_req), 32'd0);
    check("rst_if_valid", 32'(bus.if_valid), 32'd0);
    check("rst_fault", 32'(fetch_fault), 32'd0);
    check("rst_addr", bus.imem_addr, 32'h0);
    check("rst_wrap_addr", bus2.imem_addr, 32'hFFFF_FFFC);
    do_reset();

    // Stream with zero-wait memory; wrap instance runs alongside
    step();
    check("s_req0", 32'(bus.imem_req), 32'd1);
    check("s_addr0", bus.imem_addr, 32'h0);
    check("wrap_addr0", bus2.imem_addr, 32'hFFFF_FFFC);
    step();
    step();
    check("s_valid0", 32'(bus.if_valid), 32'd1);
    check("s_pc0", bus.if_pc, 32'h0);
    check("s_instr0", bus.if_instr, 32'hC0DE_0000);
    check("s_pc4_0", bus.if_pc_plus4, 32'h4);
    check("wrap_pc", bus2.if_pc, 32'hFFFF_FFFC);
    check("wrap_pc_plus4", bus2.if_pc_plus4, 32'h0);
    step();
    check("s_addr1", bus.imem_addr, 32'h4);
    check("wrap_addr1", bus2.imem_addr, 32'h0);
    check("wrap_req1", 32'(bus2.imem_req), 32'd1);
    step();
    step();
    check("s_pc1", bus.if_pc, 32'h4);
    check("s_instr1", bus.if_instr, 32'hC0DE_0004);
    step();
    check("s_req2", 32'(bus.imem_req), 32'd1);
    check("s_addr2", bus.imem_addr, 32'h8);
    check("wrap_fault", 32'(fetch_fault2), 32'd0);

    // Backpressure: two entries buffered, no further requests
    do_reset();
    bus.if_ready = 1'b0;
    repeat (8) step();
    check("bp_req_held", 32'(bus.imem_req), 32'd0);
    check("bp_valid", 32'(bus.if_valid), 32'd1);
    check("bp_head_pc", bus.if_pc, 32'h0);
    check("bp_head_instr", bus.if_instr, 32'hC0DE_0000);
    bus.if_ready = 1'b1;
    step();
    check("bp_req", 32'(bus.imem_req), 32'd1);
    check("bp_addr", bus.imem_addr, 32'h8);
    check("bp_next_pc", bus.if_pc, 32'h4);
    check("bp_next_instr", bus.if_instr, 32'hC0DE_0004);

    // Reset in the middle of a transaction
    do_reset();
    bus.if_ready = 1'b0;
    repeat (4) step();
    check("mr_pre_req", 32'(bus.imem_req), 32'd1);
    check("mr_pre_valid", 32'(bus.if_valid), 32'd1);
    step();
    rst_n = 1'b0;
    bus.imem_rvalid = 1'b0;
    mem_pend = 1'b0;
    #1;
    check("mr_req", 32'(bus.imem_req), 32'd0);
    check("mr_if_valid", 32'(bus.if_valid), 32'd0);
    do_reset();
    bus.if_ready = 1'b1;
    wait_req("mr_after", 32'h0);

    // Redirect in WAIT; the stale response must never reach decode
    do_reset();
    bus.if_ready = 1'b1;
    resp_delay = 3;
    step();
    step();
    take_branch = 1'b1;
    branch_pc   = 32'h0000_0100;
    stale_next  = 1'b1;
    stale_seen  = 1'b0;
    step();
    take_branch = 1'b0;
    check("rd_req_blocked", 32'(bus.imem_req), 32'd0);
    check("rd_fault", 32'(fetch_fault), 32'd0);
    wait_req("rd", 32'h100);
    resp_delay = 1;
    wait_valid("rd", 32'h100);
    check("rd_stale_seen", 32'(stale_seen), 32'd0);

    // Redirect and pop in the same cycle to a misaligned target
    do_reset();
    bus.if_ready = 1'b1;
    repeat (3) step();
    check("rp_pre_valid", 32'(bus.if_valid), 32'd1);
    take_branch = 1'b1;
    branch_pc   = 32'h0000_0102;
    step();
    take_branch = 1'b0;
    check("rp_flushed", 32'(bus.if_valid), 32'd0);
    check("rp_fault", 32'(fetch_fault), 32'd1);
    check("rp_req", 32'(bus.imem_req), 32'd1);
    check("rp_addr", bus.imem_addr, 32'h100);
    step();
    check("rp_fault_pulse", 32'(fetch_fault), 32'd0);
    step();
    check("rp_valid", 32'(bus.if_valid), 32'd1);
    check("rp_pc", bus.if_pc, 32'h100);
    check("rp_instr", bus.if_instr, 32'hC0DE_0100);
    check("rp_pc_plus4", bus.if_pc_plus4, 32'h104);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end
endmodule
